// File: rtl/sipo_deserializer_param_if.sv
// Serial-capture and parallel-handshake bundle for sipo_deserializer_param.
// Parity_Error_Out is present only when SIPO_PARITY_EN is defined.
interface sipo_deserializer_param_if #(
  parameter int DATA_WIDTH = 16
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic                  Serial_Data_In;
  logic                  Serial_Valid_In;
  logic                  Frame_Start_In;
  logic [DATA_WIDTH-1:0] Parallel_Data_Out;
  logic                  Parallel_Valid_Out;
  logic                  Parallel_Ready_In;
  logic [CNT_W-1:0]      Bit_Count_Out;
  logic                  Overflow_Out;
  logic                  Overflow_Clear_In;
`ifdef SIPO_PARITY_EN
  logic                  Parity_Error_Out;
`endif

  modport master (
    output Serial_Data_In,
    output Serial_Valid_In,
    output Frame_Start_In,
    output Parallel_Ready_In,
    output Overflow_Clear_In,
    input  Parallel_Data_Out,
    input  Parallel_Valid_Out,
    input  Bit_Count_Out,
    input  Overflow_Out
`ifdef SIPO_PARITY_EN
    , input Parity_Error_Out
`endif
  );

  modport slave (
    input  Serial_Data_In,
    input  Serial_Valid_In,
    input  Frame_Start_In,
    input  Parallel_Ready_In,
    input  Overflow_Clear_In,
    output Parallel_Data_Out,
    output Parallel_Valid_Out,
    output Bit_Count_Out,
    output Overflow_Out
`ifdef SIPO_PARITY_EN
    , output Parity_Error_Out
`endif
  );
endinterface

// File: rtl/sipo_deserializer_param.sv
// Parametrised serial-in/parallel-out deserializer with holding register, handshake
// and sticky overflow. Define SIPO_PARITY_EN to append an even-parity bit to each frame.
module sipo_deserializer_param #(
  parameter int DATA_WIDTH = 16,
  parameter bit MSB_FIRST  = 1'b0
) (
  input logic                      Clk_In,
  input logic                      Reset_In,
  sipo_deserializer_param_if.slave sipo
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
`ifdef SIPO_PARITY_EN
  localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
  localparam int FRAME_BITS = DATA_WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_base, shift_next;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_base;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  capture, restart, complete;
  logic                  xfer, load, drop;
`ifdef SIPO_PARITY_EN
  logic                  word_perr;
  logic                  perr_q, perr_d;
`endif

  // A frame start restarts the word from an empty register before the new bit lands.
  always_comb begin
    capture    = sipo.Serial_Valid_In;
    restart    = capture && sipo.Frame_Start_In;
    shift_base = restart ? '0 : shift_q;
    cnt_base   = restart ? '0 : cnt_q;
    complete   = capture && (cnt_base == LAST_CNT);

    if (MSB_FIRST)
      shift_next = {shift_base[DATA_WIDTH-2:0], sipo.Serial_Data_In};
    else
      shift_next = {sipo.Serial_Data_In, shift_base[DATA_WIDTH-1:1]};

`ifdef SIPO_PARITY_EN
    // The last bit of a frame is parity: it is checked, never shifted in.
    word      = shift_base;
    word_perr = (^shift_base) ^ sipo.Serial_Data_In;
    shift_d   = capture ? (complete ? shift_base : shift_next) : shift_q;
`else
    word      = shift_next;
    shift_d   = capture ? shift_next : shift_q;
`endif

    if (!capture)
      cnt_d = cnt_q;
    else if (complete)
      cnt_d = '0;
    else
      cnt_d = cnt_base + CNT_W'(1);
  end

  // A completed word is accepted if the holding register is empty or draining this edge.
  always_comb begin
    xfer    = valid_q && sipo.Parallel_Ready_In;
    load    = complete && (!valid_q || sipo.Parallel_Ready_In);
    drop    = complete && valid_q && !sipo.Parallel_Ready_In;
    data_d  = load ? word : data_q;
    valid_d = load || (valid_q && !xfer);
    ovf_d   = drop || (ovf_q && !sipo.Overflow_Clear_In);
`ifdef SIPO_PARITY_EN
    perr_d  = load ? word_perr : perr_q;
`endif
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
`ifdef SIPO_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign sipo.Parallel_Data_Out  = data_q;
  assign sipo.Parallel_Valid_Out = valid_q;
  assign sipo.Bit_Count_Out      = cnt_q;
  assign sipo.Overflow_Out       = ovf_q;
`ifdef SIPO_PARITY_EN
  assign sipo.Parity_Error_Out   = perr_q;
`endif
endmodule
